// File: rtl/place_engine_if.sv
// Placement request/result bus between a requester and place_engine.
interface place_engine_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_w;
  logic [2:0] req_h;
  logic       clear;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic [3:0] strike_out;
  logic       out_valid;
  logic       fail;

  modport master (
    output req_valid, req_w, req_h, clear,
    input  req_ready, x_out, y_out, strike_out, out_valid, fail
  );

  modport slave (
    input  req_valid, req_w, req_h, clear,
    output req_ready, x_out, y_out, strike_out, out_valid, fail
  );
endinterface

// File: rtl/place_engine.sv
// First-fit rectangle placer over a GRID x GRID occupancy map.
// One candidate corner is tested per SCAN cycle in row-major order.
module place_engine #(
  parameter int GRID = 16
) (
  input logic           clk,
  input logic           rst,
  place_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, FAIL} state_t;

  state_t state, state_nxt;

  // occ[row][col], 1 = occupied
  logic [GRID-1:0][GRID-1:0] occ;
  logic [GRID-1:0][GRID-1:0] cand_mask;
  logic [GRID-1:0]           row_bits;
  logic [2:0]                w_q, h_q;
  logic [7:0]                cx, cy;
  logic [7:0]                last_x, last_y;
  logic [7:0]                x_q, y_q;
  logic [3:0]                strike_q;
  logic                      out_valid_q;
  logic                      fit, row_end, last_cand, size_ok, accept;

  assign accept  = bus.req_valid && bus.req_ready;
  assign size_ok = (bus.req_w >= 3'd1) && (bus.req_w <= 3'd4) &&
                   (bus.req_h >= 3'd1) && (bus.req_h <= 3'd4);

  assign last_x    = 8'(GRID) - {5'd0, w_q};
  assign last_y    = 8'(GRID) - {5'd0, h_q};
  assign row_end   = (cx == last_x);
  assign last_cand = row_end && (cy == last_y);

  // Footprint of the current candidate as a full-map mask; fits if it
  // overlaps nothing already placed.
  always_comb begin
    row_bits = ((GRID'(1) << w_q) - GRID'(1)) << cx;
    for (int r = 0; r < GRID; r++)
      cand_mask[r] = (r >= int'(cy) && r < int'(cy) + int'(h_q)) ? row_bits : '0;
    fit = ~|(occ & cand_mask);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and Moore-style handshake/fail outputs.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.fail      = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = !bus.clear;
        if (accept) state_nxt = size_ok ? SCAN : FAIL;
      end
      SCAN: begin
        if (fit)            state_nxt = IDLE;
        else if (last_cand) state_nxt = FAIL;
      end
      FAIL: begin
        bus.fail  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Map, candidate walk and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      cx          <= '0;
      cy          <= '0;
      x_q         <= '0;
      y_q         <= '0;
      strike_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear) begin
            occ      <= '0;
            strike_q <= '0;
          end else if (accept) begin
            w_q <= bus.req_w;
            h_q <= bus.req_h;
            cx  <= '0;
            cy  <= '0;
          end
        end
        SCAN: begin
          if (fit) begin
            occ         <= occ | cand_mask;
            x_q         <= cx;
            y_q         <= cy;
            out_valid_q <= 1'b1;
          end else if (row_end) begin
            cx <= '0;
            cy <= cy + 8'd1;
          end else begin
            cx <= cx + 8'd1;
          end
        end
        FAIL: begin
          if (strike_q != 4'hf) strike_q <= strike_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.x_out      = x_q;
  assign bus.y_out      = y_q;
  assign bus.strike_out = strike_q;
  assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_place_engine.sv
// Scoreboard bench for place_engine: a reference first-fit model predicts
// corner, latency and strike count for every accepted request.
module tb_place_engine;
  localparam int GRID = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  place_engine_if bus();

  place_engine #(.GRID(GRID)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic ok;
    int   cyc;
    int   x;
    int   y;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  bit   mmap [GRID][GRID];
  int   m_strike, m_x, m_y;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Pop the oldest expectation whenever a result pulse is visible.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && (bus.out_valid || bus.fail)) begin
      chk("excl", int'(bus.out_valid && bus.fail), 0);
      if (q.size() == 0) chk("unexpected", 1, 0);
      else begin
        e = q.pop_front();
        chk("kind", int'(bus.out_valid), int'(e.ok));
        chk("lat",  cyc + 1, e.cyc);
        chk("x",    int'(bus.x_out), e.x);
        chk("y",    int'(bus.y_out), e.y);
      end
    end
  end

  function automatic void model_reset();
    for (int r = 0; r < GRID; r++)
      for (int c = 0; c < GRID; c++) mmap[r][c] = 1'b0;
    m_strike = 0;
  endfunction

  task automatic model_place(input int w, input int h,
                             output logic ok, output int lat);
    int  k = 0;
    bit  found = 0;
    bit  free;
    ok = 1'b0;
    if (w < 1 || w > 4 || h < 1 || h > 4) begin
      lat = 1;
    end else begin
      for (int y = 0; y <= GRID - h && !found; y++)
        for (int x = 0; x <= GRID - w && !found; x++) begin
          free = 1;
          for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
              if (mmap[y+j][x+i]) free = 0;
          if (free) begin
            found = 1;
            for (int j = 0; j < h; j++)
              for (int i = 0; i < w; i++) mmap[y+j][x+i] = 1'b1;
            m_x = x;
            m_y = y;
          end else k++;
        end
      ok  = found;
      lat = found ? 2 + k : 1 + k;
    end
    if (!ok && m_strike < 15) m_strike++;
  endtask

  // Drive one request at a negedge; returns at the negedge after accept.
  task automatic issue(int w, int h);
    logic ok;
    int   lat;
    exp_t e;
    int   t = 0;
    while (!bus.req_ready && t < 50) begin @(negedge clk); t++; end
    if (!bus.req_ready) chk("ready", 0, 1);
    model_place(w, h, ok, lat);
    e.ok = ok; e.cyc = cyc + 1 + lat; e.x = m_x; e.y = m_y;
    q.push_back(e);
    bus.req_w     = 3'(w);
    bus.req_h     = 3'(h);
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (q.size() != 0 && t < 400) begin @(negedge clk); t++; end
    if (q.size() != 0) begin
      chk("timeout", 0, 1);
      q.delete();
    end
    @(negedge clk);
    chk("strike", int'(bus.strike_out), m_strike);
  endtask

  // clr_cycles > 0 holds clear high during the scan right after accept.
  task automatic req(int w, int h, int clr_cycles = 0);
    issue(w, h);
    if (clr_cycles > 0) begin
      bus.clear = 1'b1;
      repeat (clr_cycles) @(negedge clk);
      bus.clear = 1'b0;
    end
    wait_done();
  endtask

  task automatic do_clear(logic with_valid);
    bus.clear     = 1'b1;
    bus.req_valid = with_valid;
    bus.req_w     = 3'd1;
    bus.req_h     = 3'd1;
    #1 chk("ready_clr", int'(bus.req_ready), 0);
    @(negedge clk);
    bus.clear     = 1'b0;
    bus.req_valid = 1'b0;
    model_reset();
    chk("strike_clr", int'(bus.strike_out), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    m_x = 0;
    m_y = 0;
    chk("rst_x",     int'(bus.x_out), 0);
    chk("rst_y",     int'(bus.y_out), 0);
    chk("rst_strk",  int'(bus.strike_out), 0);
    chk("rst_ov",    int'(bus.out_valid), 0);
    chk("rst_fail",  int'(bus.fail), 0);
    chk("rst_ready", int'(bus.req_ready), 1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_w     = 3'd0;
    bus.req_h     = 3'd0;
    bus.clear     = 1'b0;
    rst           = 1'b1;
    repeat (2) @(negedge clk);
    do_reset();

    // Two 2x2: (0,0) then (2,0).
    req(2, 2);
    req(2, 2);

    // Clear beats req_valid; map empty afterwards.
    do_clear(1'b1);
    req(1, 1);

    // Fill the map with 4x4 tiles, then overflow.
    do_clear(1'b0);
    for (int i = 0; i < 16; i++) req(4, 4);
    req(4, 4);

    // Illegal sizes, then confirm map still full.
    req(0, 2);
    req(2, 5);
    req(4, 4);

    // Strike saturation.
    for (int i = 0; i < 16; i++) req(1, 1);

    // Clear during a long failing scan is ignored.
    req(1, 1, 250);

    // Clear during a successful scan is ignored.
    do_clear(1'b0);
    req(2, 2);
    req(2, 2, 2);

    // Reset mid-scan abandons the request.
    req(0, 1);
    issue(4, 4);
    @(negedge clk);
    do_reset();
    repeat (10) @(negedge clk);
    req(1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/place_engine.md
PLACE_ENGINE -- requirements
Module: place_engine

Interface
REQ-001 SHALL declare parameter GRID, default 16, meaning the occupancy map is GRID x GRID cells; only 16 is required to be supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1 bit: a placement request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the engine can accept a request.
REQ-006 SHALL have port req_w, input, 3 bits: program width in cells; legal range 1..4.
REQ-007 SHALL have port req_h, input, 3 bits: program height in cells; legal range 1..4.
REQ-008 SHALL have port clear, input, 1 bit: empties the occupancy map and zeroes the strike count.
REQ-009 SHALL have ports x_out and y_out, outputs, 8 bits each: registered top-left corner of the last successful placement.
REQ-010 SHALL have port strike_out, output, 4 bits: registered count of failed requests.
REQ-011 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a successful placement.
REQ-012 SHALL have port fail, output, 1 bit: one-cycle pulse marking a failed request.

Function
REQ-013 SHALL implement the FSM states IDLE, SCAN and FAIL, plus an internal GRID*GRID-bit occupancy map (1 = occupied).
REQ-014 SHALL drive req_ready = (state==IDLE) && !clear, combinationally.
REQ-015 SHALL accept a request on an edge where req_valid && req_ready (the accept edge); at that edge it latches w and h and sets candidate (cx,cy) = (0,0).
REQ-016 SHALL transition from IDLE to SCAN on accept when 1<=w<=4 and 1<=h<=4, and to FAIL otherwise.
REQ-017 SHALL evaluate exactly one candidate per SCAN cycle; a candidate fits iff every cell (cx+i, cy+j), i<w, j<h, is free.
REQ-018 SHALL scan candidates in row-major order (cx fastest), with cx in 0..GRID-w and cy in 0..GRID-h, so N = (GRID-w+1)*(GRID-h+1).
REQ-019 SHALL wrap within the same edge when a candidate misses: after cx = GRID-w the next candidate is (0, cy+1); no cycle is spent on out-of-range positions.
REQ-020 SHALL, on a fit, in one edge: set all w*h cells occupied, load x_out=cx and y_out=cy (zero-extended), pulse out_valid, and return to IDLE.
REQ-021 SHALL have success latency accept edge + 2 + k, where k is the number of candidates rejected before the fit.
REQ-022 SHALL go to FAIL when the last candidate (GRID-w, GRID-h) misses; the fail pulse then occurs at accept edge + 1 + N.
REQ-023 SHALL, in FAIL, take one cycle: pulse fail, increment strike_out saturating at 15, leave the map unchanged, and return to IDLE.
REQ-024 SHALL signal an illegal size with the fail pulse at accept edge + 1.
REQ-025 SHALL hold x_out and y_out until the next success; fail does not change them.
REQ-026 SHALL act on clear only in IDLE: the map and strike_out are zeroed at that edge, and clear takes precedence over req_valid (no accept).
REQ-027 SHALL ignore clear in SCAN and FAIL.
REQ-028 SHALL never assert out_valid and fail in the same cycle.

Reset
REQ-029 SHALL, on rst high at an edge, set state=IDLE, empty the map, and set x_out=0, y_out=0, strike_out=0, out_valid=0, fail=0; rst overrides every other input.
REQ-030 SHALL abandon any in-flight request on rst during SCAN or FAIL without updating the map; req_ready is 1 in the cycle after rst deasserts, provided clear is low.

Verification
REQ-031 SHALL pass: after rst, 2x2 request -> out_valid at accept+2, x=0, y=0, strike=0; a second 2x2 -> x=2, y=0, out_valid at accept+4.
REQ-032 SHALL pass: sixteen 4x4 requests on an empty map -> corners (0,0),(4,0),(8,0),(12,0),(0,4)...(12,12); a 17th 4x4 -> fail at accept+170, strike=1, x=12 and y=12 held.
REQ-033 SHALL pass: w=0 or h=5 request -> fail at accept+1, map unchanged, strike +1; with a full map, sixteen further fails -> strike stays 15.
REQ-034 SHALL pass: clear in IDLE with req_valid also high -> no accept, map empty, strike=0; next 1x1 -> x=0, y=0.
REQ-035 SHALL pass: clear asserted during SCAN -> ignored, and the scan completes normally.
REQ-036 SHALL pass: rst asserted mid-SCAN -> all outputs 0, no out_valid or fail for that request, map empty, req_ready=1 on the next cycle.
